// File: rtl/lm32_irq_pkg.sv
// Shared definitions for the LM32 interrupt controller: register map, FSM encoding
// and VECTOR read layout.
package lm32_irq_pkg;

    localparam logic [2:0] AdrPend   = 3'd0;
    localparam logic [2:0] AdrMask   = 3'd1;
    localparam logic [2:0] AdrVector = 3'd2;
    localparam logic [2:0] AdrEoi    = 3'd3;
    localparam logic [2:0] AdrMode   = 3'd4;

    localparam int unsigned WinW        = 5;
    localparam int unsigned VecValidBit = 31;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StService
    } irq_state_e;

endpackage

// File: rtl/lm32_irq_prio.sv
// Combinational priority encoder: lowest set candidate index wins.
module lm32_irq_prio
    import lm32_irq_pkg::*;
#(
    parameter int unsigned SOURCES = 8
) (
    input  logic [SOURCES-1:0] cand_i,
    output logic [WinW-1:0]    win_o,
    output logic               valid_o
);

    // Scan from the top so the lowest index is the last assignment and wins.
    always_comb begin
        win_o = '0;
        for (int i = int'(SOURCES) - 1; i >= 0; i--) begin
            if (cand_i[i]) begin
                win_o = WinW'(i);
            end
        end
    end

    assign valid_o = |cand_i;

endmodule

// File: rtl/lm32_irq_ctrl.sv
// Wishbone interrupt controller driving one active-low LM32 interrupt pin.
// Define CFG_IRQ_EDGE_EN to add per-source edge-triggered mode (MODE register).
module lm32_irq_ctrl
    import lm32_irq_pkg::*;
#(
    parameter int unsigned SOURCES = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SOURCES-1:0] irq_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [2:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               interrupt_n
);

    irq_state_e         state_q, state_d;
    logic [SOURCES-1:0] pend_q, pend_d;
    logic [SOURCES-1:0] mask_q, mask_d;
    logic [SOURCES-1:0] cand;
    logic [WinW-1:0]    win, cur_q, cur_d;
    logic               any;
    logic               ack_q;
    logic               bus_req, xfer, bus_wr, bus_rd;
    logic               vec_rd, eoi_hit;
    logic [31:0]        rdata, mode_rd;
    logic               unused_dat;

    assign unused_dat = ^wb_dat_i;

    // Side effects commit at the end of the ack cycle, so new state is seen after ack.
    assign bus_req = wb_cyc_i & wb_stb_i;
    assign xfer    = bus_req & ack_q;
    assign bus_wr  = xfer & wb_we_i;
    assign bus_rd  = xfer & ~wb_we_i;

    assign cand    = pend_q & mask_q;
    assign vec_rd  = bus_rd && (wb_adr_i == AdrVector) && (state_q == StAssert) && any;
    assign eoi_hit = bus_wr && (wb_adr_i == AdrEoi) && (state_q == StService)
                     && (wb_dat_i[WinW-1:0] == cur_q);

    lm32_irq_prio #(
        .SOURCES (SOURCES)
    ) u_prio (
        .cand_i  (cand),
        .win_o   (win),
        .valid_o (any)
    );

    always_comb begin
        mask_d = mask_q;
        if (bus_wr && (wb_adr_i == AdrMask)) begin
            mask_d = wb_dat_i[SOURCES-1:0];
        end
    end

    assign cur_d = vec_rd ? win : cur_q;

`ifdef CFG_IRQ_EDGE_EN
    logic [SOURCES-1:0] mode_q, mode_d, irq_prev_q, edge_clr;

    // Edge bits hold until cleared; a new rising edge in the clear cycle wins.
    always_comb begin
        mode_d = mode_q;
        if (bus_wr && (wb_adr_i == AdrMode)) begin
            mode_d = wb_dat_i[SOURCES-1:0];
        end
        edge_clr = '0;
        if (bus_wr && (wb_adr_i == AdrPend)) begin
            edge_clr = wb_dat_i[SOURCES-1:0];
        end
        if (eoi_hit) begin
            edge_clr = edge_clr | (SOURCES'(1) << cur_q);
        end
        pend_d = (mode_q & ((pend_q & ~edge_clr) | (irq_i & ~irq_prev_q)))
                 | (~mode_q & irq_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q     <= '0;
            irq_prev_q <= '0;
        end else begin
            mode_q     <= mode_d;
            irq_prev_q <= irq_i;
        end
    end

    assign mode_rd = 32'(mode_q);
`else
    assign pend_d  = irq_i;
    assign mode_rd = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pend_q  <= '0;
            mask_q  <= '0;
            cur_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            ack_q   <= bus_req & ~ack_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any) state_d = StAssert;
            end
            StAssert: begin
                if (!any) begin
                    state_d = StIdle;
                end else if (vec_rd) begin
                    state_d = StService;
                end
            end
            StService: begin
                if (eoi_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        interrupt_n = (state_q != StAssert);
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            AdrPend: rdata = 32'(pend_q);
            AdrMask: rdata = 32'(mask_q);
            AdrVector: begin
                if ((state_q == StAssert) && any) begin
                    rdata[VecValidBit] = 1'b1;
                    rdata[WinW-1:0]    = win;
                end
            end
            AdrMode: rdata = mode_rd;
            default: rdata = '0;
        endcase
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = ack_q ? rdata : '0;

endmodule

// File: tb/tb_lm32_irq_ctrl.sv
// Directed self-checking bench for lm32_irq_ctrl (default 8 sources).
module tb_lm32_irq_ctrl;

    localparam logic [2:0] A_PEND = 3'd0, A_MASK = 3'd1, A_VEC = 3'd2;
    localparam logic [2:0] A_EOI = 3'd3, A_MODE = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [31:0] dat_w, dat_r;
    logic        ack, int_n;
    logic [31:0] r;

    int vectors = 0;
    int miscompares = 0;

    lm32_irq_ctrl #(
        .SOURCES (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_i       (irq),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_w),
        .wb_dat_o    (dat_r),
        .wb_ack_o    (ack),
        .interrupt_n (int_n)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
        bit got;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        got = 1'b0;
        rd  = '0;
        for (int n = 0; n < 4 && !got; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                rd  = dat_r;
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL bus_ack adr=%0d ack=0 required=1", a);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        bus_xfer(1'b0, a, 32'h0, v);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL reset_int_n got=%b exp=1", int_n); end
        vectors++;
        if (ack !== 1'b0 || dat_r !== 32'h0) begin
            miscompares++; $display("FAIL reset_bus ack=%b dat=%h exp ack=0 dat=0", ack, dat_r);
        end
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL reset_pend got=%h exp=0", r); end
        rd(A_MASK, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL reset_mask got=%h exp=0", r); end
        rd(A_MODE, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL reset_mode got=%h exp=0", r); end
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL reset_vector got=%h exp=0", r); end
    endtask

    task automatic test_basic;
        wr(A_MASK, 32'h05);
        irq = 8'h02;
        wait_cycles(3);
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL masked_src int_n=%b exp=1", int_n); end
        irq = 8'h04;
        wait_cycles(2);
        vectors++;
        if (int_n !== 1'b0) begin miscompares++; $display("FAIL basic_assert int_n=%b exp=0", int_n); end
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h04) begin miscompares++; $display("FAIL basic_pend got=%h exp=04", r); end
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h80000002) begin miscompares++; $display("FAIL basic_vector got=%h exp=80000002", r); end
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL basic_service int_n=%b exp=1", int_n); end
        irq = 8'h00;
        wr(A_EOI, 32'd2);
        wait_cycles(2);
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL idle_vector got=%h exp=0", r); end
    endtask

    task automatic test_priority;
        wr(A_MASK, 32'hFF);
        irq = 8'h06;
        wait_cycles(2);
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h80000001) begin miscompares++; $display("FAIL prio_vector got=%h exp=80000001", r); end
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL service_vector got=%h exp=0", r); end
        wr(A_EOI, 32'd1);
        wait_cycles(1);
        vectors++;
        if (int_n !== 1'b0) begin miscompares++; $display("FAIL prio_reassert int_n=%b exp=0", int_n); end
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h80000001) begin miscompares++; $display("FAIL prio_vector2 got=%h exp=80000001", r); end
        irq = 8'h00;
        wr(A_EOI, 32'd1);
        wait_cycles(2);
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL prio_done int_n=%b exp=1", int_n); end
    endtask

    task automatic test_drop;
        irq = 8'h08;
        wait_cycles(2);
        vectors++;
        if (int_n !== 1'b0) begin miscompares++; $display("FAIL drop_assert int_n=%b exp=0", int_n); end
        wr(A_MASK, 32'h00);
        wait_cycles(1);
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL mask_drop int_n=%b exp=1", int_n); end
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL mask_drop_vector got=%h exp=0", r); end
        irq = 8'h00;
        wr(A_MASK, 32'hFF);
        irq = 8'h10;
        wait_cycles(2);
        vectors++;
        if (int_n !== 1'b0) begin miscompares++; $display("FAIL src_assert int_n=%b exp=0", int_n); end
        irq = 8'h00;
        wait_cycles(2);
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL src_drop int_n=%b exp=1", int_n); end
    endtask

    task automatic test_eoi_mismatch;
        irq = 8'h04;
        wait_cycles(2);
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h80000002) begin miscompares++; $display("FAIL eoi_vector got=%h exp=80000002", r); end
        irq = 8'h00;
        wr(A_EOI, 32'd5);
        irq = 8'h01;
        wait_cycles(3);
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL eoi_mismatch int_n=%b exp=1", int_n); end
        wr(A_EOI, 32'd2);
        wait_cycles(1);
        vectors++;
        if (int_n !== 1'b0) begin miscompares++; $display("FAIL eoi_match int_n=%b exp=0", int_n); end
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h80000000) begin miscompares++; $display("FAIL eoi_next_vector got=%h exp=80000000", r); end
        irq = 8'h00;
        wr(A_EOI, 32'd0);
        wait_cycles(2);
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL eoi_done int_n=%b exp=1", int_n); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_MASK;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (ack !== ((i % 2) == 0) || dat_r !== (((i % 2) == 0) ? 32'hFF : 32'h0)) begin
                miscompares++;
                $display("FAIL b2b_ack[%0d] ack=%b dat=%h exp ack=%0d", i, ack, dat_r, (i % 2) == 0);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        wait_cycles(1);
        rd(3'd6, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got=%h exp=0", r); end
        rd(A_EOI, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL eoi_read got=%h exp=0", r); end
        wr(3'd7, 32'h0);
        rd(A_MASK, r);
        vectors++;
        if (r !== 32'hFF) begin miscompares++; $display("FAIL unmapped_write mask=%h exp=ff", r); end
    endtask

`ifdef CFG_IRQ_EDGE_EN
    task automatic test_edge;
        wr(A_MODE, 32'h01);
        wr(A_MASK, 32'h01);
        rd(A_MODE, r);
        vectors++;
        if (r !== 32'h01) begin miscompares++; $display("FAIL edge_mode got=%h exp=01", r); end
        irq = 8'h01;
        wait_cycles(1);
        irq = 8'h00;
        wait_cycles(2);
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h01) begin miscompares++; $display("FAIL edge_held got=%h exp=01", r); end
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h80000000) begin miscompares++; $display("FAIL edge_vector got=%h exp=80000000", r); end
        // EOI 0 with a fresh pulse landing in the commit cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_EOI; dat_w = 32'd0;
        @(posedge clk); #1;
        irq = 8'h01;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; irq = 8'h00;
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h01) begin miscompares++; $display("FAIL edge_set_wins got=%h exp=01", r); end
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h80000000) begin miscompares++; $display("FAIL edge_vector2 got=%h exp=80000000", r); end
        wr(A_EOI, 32'd0);
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h00) begin miscompares++; $display("FAIL edge_eoi_clear got=%h exp=00", r); end
        irq = 8'h01;
        wait_cycles(1);
        irq = 8'h00;
        wr(A_PEND, 32'h01);
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h00) begin miscompares++; $display("FAIL edge_w1c got=%h exp=00", r); end
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL edge_idle int_n=%b exp=1", int_n); end
        wr(A_MODE, 32'h00);
    endtask
`else
    task automatic test_edge;
        wr(A_MODE, 32'hFF);
        rd(A_MODE, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL mode_ignored got=%h exp=0", r); end
        wr(A_MASK, 32'h00);
        irq = 8'h01;
        wr(A_PEND, 32'h01);
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h01) begin miscompares++; $display("FAIL pend_write_ignored got=%h exp=01", r); end
        irq = 8'h00;
        wait_cycles(1);
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h00) begin miscompares++; $display("FAIL level_follow got=%h exp=00", r); end
    endtask
`endif

    task automatic test_reset_in_flight;
        wr(A_MASK, 32'hFF);
        irq = 8'h04;
        wait_cycles(2);
        rd(A_VEC, r);
        vectors++;
        if (r !== 32'h80000002) begin miscompares++; $display("FAIL rif_vector got=%h exp=80000002", r); end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_VEC;
        #2;
        rst = 1'b1; irq = 8'h00;
        @(posedge clk); #1;
        vectors++;
        if (ack !== 1'b0 || int_n !== 1'b1 || dat_r !== 32'h0) begin
            miscompares++;
            $display("FAIL rif_no_ack ack=%b int_n=%b dat=%h exp 0/1/0", ack, int_n, dat_r);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (ack !== 1'b1 || dat_r !== 32'h0) begin
            miscompares++; $display("FAIL rif_retry ack=%b dat=%h exp ack=1 dat=0", ack, dat_r);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        rd(A_MASK, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL rif_mask got=%h exp=0", r); end
        rd(A_PEND, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL rif_pend got=%h exp=0", r); end
    endtask

    initial begin
        rst = 1'b1; irq = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (int_n !== 1'b1) begin miscompares++; $display("FAIL in_reset int_n=%b exp=1", int_n); end
        @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_basic;
        test_priority;
        test_drop;
        test_eoi_mismatch;
        test_back_to_back;
        test_edge;
        test_reset_in_flight;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lm32_irq_ctrl.md
LM32_IRQ_CTRL -- requirements
Module: lm32_irq_ctrl

Interface
REQ-001 SHALL have parameter SOURCES, default 8, number of peripheral interrupt sources (legal 1..32).
REQ-002 SHALL have port clk_i  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port irq_i  input  SOURCES  peripheral requests, active-high, synchronous to clk_i.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone slave cycle, strobe and write enable.
REQ-006 SHALL have port wb_adr_i  input  3  word address (byte address bits 4:2).
REQ-007 SHALL have port wb_dat_i  input  32  write data.
REQ-008 SHALL have port wb_dat_o  output  32  read data, valid while wb_ack_o=1, zero otherwise.
REQ-009 SHALL have port wb_ack_o  output  1  single-cycle transfer acknowledge.
REQ-010 SHALL have port interrupt_n  output  1  active-low request to one CPU interrupt pin.

Function
REQ-011 SHALL keep PEND[SOURCES-1:0]; level source: PEND bit = irq_i bit registered each cycle.
REQ-012 SHALL have register map: 0 PEND (RO), 1 MASK (RW, 1=enabled), 2 VECTOR (RO), 3 EOI (WO), 4 MODE (RW, edge mode, see REQ-025); other addresses read 0, writes ignored.
REQ-013 SHALL assert wb_ack_o exactly one cycle after wb_cyc_i&wb_stb_i are sampled high with wb_ack_o low; never two consecutive ack cycles.
REQ-014 SHALL compute CAND = PEND & MASK; WIN = lowest set index of CAND (index 0 highest priority).
REQ-015 SHALL run FSM IDLE/ASSERT/SERVICE; interrupt_n low only in ASSERT (registered output).
REQ-016 IDLE->ASSERT when CAND!=0.
REQ-017 ASSERT->SERVICE on acked VECTOR read; latch CUR=WIN; read returns {1'b1, 26'b0, WIN[4:0]}.
REQ-018 ASSERT->IDLE when CAND becomes 0 (source drop or masking) without VECTOR read.
REQ-019 VECTOR read outside ASSERT SHALL return 0 (bit31=0) and not change state.
REQ-020 SERVICE->IDLE on EOI write with wb_dat_i[4:0]==CUR; mismatched EOI ignored; CUR pending sources not re-reported until EOI.
REQ-021 MASK write SHALL take effect on CAND the cycle after ack.

Reset
REQ-022 On rst_i: FSM=IDLE, PEND=0, MASK=0, MODE=0, CUR=0, wb_ack_o=0, wb_dat_o=0, interrupt_n=1, regardless of bus cycle in progress.
REQ-023 Bus cycle in flight at reset SHALL not be acked; master retries.

Configuration
REQ-024 Macro CFG_IRQ_EDGE_EN SHALL select edge-detect support.
REQ-025 With CFG_IRQ_EDGE_EN: MODE bit=1 makes source edge-triggered: PEND bit set on irq_i 0->1 and held; cleared by matching EOI or PEND write-1-to-clear; set in same cycle as clear wins.
REQ-026 Without CFG_IRQ_EDGE_EN: no edge registers; MODE reads 0, writes ignored; PEND writes ignored; all sources level.

Structure
REQ-027 Register addresses, FSM state encoding and VECTOR valid-bit position SHALL live in shared package lm32_irq_pkg.
REQ-028 Priority encoder SHALL be sub-module lm32_irq_prio (CAND in, WIN and any-valid out, combinational).

Verification
REQ-029 MASK=0x05, irq_i=0x04 -> interrupt_n low within 2 cycles; VECTOR read=0x80000002; interrupt_n high next cycle.
REQ-030 irq_i=0x06, MASK=0xFF -> VECTOR=0x80000001; EOI 1 with irq_i[1] still high -> re-enter ASSERT, VECTOR=0x80000001 again.
REQ-031 ASSERT on source 3, MASK write 0x00 before VECTOR read -> IDLE, interrupt_n high, VECTOR read=0x00000000.
REQ-032 SERVICE on CUR=2, EOI 5 -> stays SERVICE, interrupt_n high; EOI 2 -> IDLE.
REQ-033 CFG_IRQ_EDGE_EN, MODE=0x01, 1-cycle pulse on irq_i[0] -> PEND=0x01 held, VECTOR=0x80000000, EOI 0 clears PEND; new pulse on EOI cycle keeps PEND=0x01.
REQ-034 rst_i asserted in SERVICE during VECTOR read -> no ack, interrupt_n=1, PEND=MASK=0 immediately.
